// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and a counter-width helper.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the shift-add multiplier: sequences CHECK/ADD/SHIFT per
// multiplier bit and holds DONE for a programmable number of cycles.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int DONE_HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic lsb_b,
  input  logic b_next_zero,
  input  logic last_bit,
  output logic load,
  output logic add,
  output logic sh,
  output logic done,
  output logic busy
);

  localparam int HW = cnt_w(DONE_HOLD);

  state_e        state_q;
  logic [HW-1:0] hold_q;
  logic          done_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            state_q <= ST_CHECK;
            busy_q  <= 1'b1;
          end
        end
        ST_CHECK: state_q <= lsb_b ? ST_ADD : ST_SHIFT;
        ST_ADD:   state_q <= ST_SHIFT;
        ST_SHIFT: begin
          // Stop as soon as no set multiplier bits remain above this one.
          if (b_next_zero || last_bit) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_DONE: begin
          if (hold_q == HW'(DONE_HOLD - 1)) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load = (state_q == ST_IDLE) && init;
  assign add  = (state_q == ST_ADD);
  assign sh   = (state_q == ST_SHIFT);
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/mult_seq_param.sv
// Parametrised radix-2 shift-add multiplier with optional two's-complement
// mode, early termination and a held done window.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DONE_HOLD = 10,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int PW  = 2 * WIDTH;
  localparam int BCW = cnt_w(WIDTH);

  logic             sm_eff;
  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic             neg_q;
  logic [PW-1:0]    result_q;

  logic load, add, sh;
  logic b_next_zero, last_bit;

  assign sm_eff = (SIGNED_EN != 0) && signed_mode;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign mag_a_d = (sm_eff && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b_d = (sm_eff && op_b[WIDTH-1]) ? -op_b : op_b;

  assign b_next_zero = (b_sh_q[WIDTH-1:1] == '0);
  assign last_bit    = (bit_cnt_q == BCW'(WIDTH - 1));

  mult_seq_ctrl #(
    .DONE_HOLD(DONE_HOLD)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .lsb_b      (b_sh_q[0]),
    .b_next_zero(b_next_zero),
    .last_bit   (last_bit),
    .load       (load),
    .add        (add),
    .sh         (sh),
    .done       (done),
    .busy       (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      bit_cnt_q <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      if (load) begin
        acc_q     <= '0;
        a_sh_q    <= {{WIDTH{1'b0}}, mag_a_d};
        b_sh_q    <= mag_b_d;
        bit_cnt_q <= '0;
        neg_q     <= sm_eff && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end
      if (add) begin
        acc_q <= acc_q + a_sh_q;
      end
      if (sh) begin
        a_sh_q    <= a_sh_q << 1;
        b_sh_q    <= b_sh_q >> 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
        // acc_q already holds this iteration's ADD, since ADD precedes SHIFT.
        if (b_next_zero || last_bit) begin
          result_q <= neg_q ? -acc_q : acc_q;
        end
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: 8-bit signed-capable instance plus a
// 32-bit unsigned-only instance, sharing clock and reset.
module tb_mult_seq_param;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        init = 1'b0;
  logic        sm = 1'b0;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic        busy, done;
  logic [15:0] result;

  logic        init_w = 1'b0;
  logic        sm_w = 1'b0;
  logic [31:0] op_a_w = '0;
  logic [31:0] op_b_w = '0;
  logic        busy_w, done_w;
  logic [63:0] result_w;

  logic [15:0] exp_q[$];
  logic [63:0] exp_w_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(8), .DONE_HOLD(HOLD), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .init(init), .signed_mode(sm),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  mult_seq_param #(.WIDTH(32), .DONE_HOLD(HOLD), .SIGNED_EN(0)) dut_w (
    .clk(clk), .rst(rst), .init(init_w), .signed_mode(sm_w),
    .op_a(op_a_w), .op_b(op_b_w), .busy(busy_w), .done(done_w), .result(result_w)
  );

  function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = $signed({{8{a[7]}}, a});
      sb = $signed({{8{b[7]}}, b});
      return 16'(sa * sb);
    end
    return 16'({8'd0, a} * {8'd0, b});
  endfunction

  // Cycles from init sample to first done: 1 + (2 or 3) per processed bit.
  function automatic int model_lat(input logic [63:0] mag);
    int hi = 0;
    int lat = 1;
    for (int i = 0; i < 64; i++) if (mag[i]) hi = i;
    for (int i = 0; i <= hi; i++) lat += mag[i] ? 3 : 2;
    return lat;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    op_a = a; op_b = b; sm = s; init = 1'b1;
    exp_q.push_back(model_prod(a, b, s));
    cyc = 0;
    tick();
    init = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_init: got %b want 1", busy);
    end
  endtask

  task automatic finish_op(input logic [7:0] b, input logic s);
    logic [7:0] mag;
    logic [15:0] exp;
    int width;
    mag = (s && b[7]) ? -b : b;
    while (!done && cyc < 300) tick();
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
      return;
    end
    if (cyc != model_lat({56'd0, mag})) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d", cyc, model_lat({56'd0, mag}));
    end
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL result: got %h want %h", result, exp);
    end
    $display("op a=%h b=%h signed=%b -> result=%h latency=%0d", op_a, b, s, result, cyc);
    width = 0;
    while (done && width < 20) begin
      width++;
      tick();
    end
    n_checks++;
    if (width != HOLD) begin
      n_fail++;
      $display("FAIL done_width: got %0d want %0d", width, HOLD);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_done: got %b want 0", busy);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    start_op(a, b, s);
    finish_op(b, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks += 2;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    if (result !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0000", result);
    end
    n_checks += 2;
    if (busy_w !== 1'b0 || done_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags_w: got busy=%b done=%b want 0 0", busy_w, done_w);
    end
    if (result_w !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_result_w: got %h want 0", result_w);
    end
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_unsigned();
    run_op(8'd13, 8'd11, 1'b0);
    run_op(8'd200, 8'd3, 1'b0);
  endtask

  task automatic test_signed();
    run_op(8'h80, 8'h80, 1'b1);
    run_op(8'hF9, 8'd5, 1'b1);
    run_op(8'd77, 8'd0, 1'b1);
    run_op(8'd6, 8'hFD, 1'b1);
  endtask

  task automatic test_early_term();
    run_op(8'd37, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'd3, 8'h40, 1'b0);
  endtask

  task automatic test_busy_ignore();
    start_op(8'd13, 8'd11, 1'b0);
    repeat (2) tick();
    op_a = 8'd99; op_b = 8'd77; init = 1'b1;
    repeat (2) tick();
    init = 1'b0;
    op_b = 8'd11;
    finish_op(8'd11, 1'b0);
    repeat (5) tick();
    n_checks += 2;
    if (result !== 16'd143) begin
      n_fail++;
      $display("FAIL result_hold_idle: got %h want 008f", result);
    end
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle: got %b want 0", busy);
    end
    $display("hold: result=%h in idle", result);
  endtask

  task automatic test_midop_reset();
    start_op(8'hFF, 8'hFF, 1'b0);
    void'(exp_q.pop_back());
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks += 2;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    if (result !== 16'd0) begin
      n_fail++;
      $display("FAIL midop_reset_result: got %h want 0000", result);
    end
    $display("midop reset: busy=%b done=%b result=%h", busy, done, result);
    run_op(8'd25, 8'd9, 1'b0);
  endtask

  task automatic test_wide();
    logic [63:0] exp;
    int width;
    op_a_w = 32'hFFFFFFFF; op_b_w = 32'hFFFFFFFF; sm_w = 1'b1; init_w = 1'b1;
    exp_w_q.push_back({32'd0, op_a_w} * {32'd0, op_b_w});
    cyc = 0;
    tick();
    init_w = 1'b0;
    while (!done_w && cyc < 300) tick();
    n_checks++;
    if (!done_w) begin
      n_fail++;
      $display("FAIL wide_timeout: no done after %0d cycles", cyc);
      return;
    end
    if (cyc != model_lat({32'd0, op_b_w})) begin
      n_fail++;
      $display("FAIL wide_latency: got %0d want %0d", cyc, model_lat({32'd0, op_b_w}));
    end
    exp = exp_w_q.pop_front();
    n_checks++;
    if (result_w !== exp) begin
      n_fail++;
      $display("FAIL wide_result: got %h want %h", result_w, exp);
    end
    $display("wide op a=%h b=%h -> result=%h latency=%0d", op_a_w, op_b_w, result_w, cyc);
    width = 0;
    while (done_w && width < 20) begin
      width++;
      tick();
    end
    n_checks++;
    if (width != HOLD) begin
      n_fail++;
      $display("FAIL wide_done_width: got %0d want %0d", width, HOLD);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_early_term();
    test_busy_ignore();
    test_midop_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
